map_port_arbiter: RTL and testbench

Arbiter and sequencer for port B of the candy/map BRAM (32×36 tiles, 4-bit tile codes, 1-cycle read latency). It shares this port between up to N_REQ requesters: pacman tile lookup/eat, ghost tile probes, and the level-restore writer. It also executes an atomic read-test-clear ("consume") operation that replaces the standalone cookie/candy strobe logic. It drives the eat strobes consumed by the score and power-mode logic.

---
 rtl/map_port_arbiter_pkg.sv | 31 +++
 rtl/map_port_arbiter_rr_priority_picker.sv | 39 +++
 rtl/map_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_map_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : map_port_arbiter_pkg
// Brief    : Shared map types and tile codes for the map BRAM port-B arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package map_port_arbiter_pkg;

    typedef enum logic [1:0] {
        MAP_OP_READ    = 2'd0,
        MAP_OP_WRITE   = 2'd1,
        MAP_OP_CONSUME = 2'd2,
        MAP_OP_RSVD    = 2'd3
    } map_op_e;

    typedef enum logic [0:0] {
        ST_ISSUE  = 1'b0,
        ST_RMW_WB = 1'b1
    } arb_state_e;

    localparam int c_map_cols = 32;
    localparam int c_map_rows = 36;

    localparam logic [3:0] c_empty_tile = 4'h0;
    localparam logic [3:0] c_candy_tile = 4'h1;
    localparam logic [3:0] c_power_tile = 4'h2;

endpackage

`default_nettype wire

// File: rtl/map_port_arbiter_rr_priority_picker.sv
//------------------------------------------------------------------------------
// Module   : rr_priority_picker
// Brief    : One-hot winner search over a request vector starting at a pointer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_priority_picker #(
    parameter int N_REQ = 6,
    parameter int PTR_W = 3
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic [PTR_W:0] w_idx;
    logic           w_found;

    // Wrap the scan index manually so non-power-of-two N_REQ works.
    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(N_REQ);
            end
            if (!w_found && req_i[w_idx[PTR_W-1:0]]) begin
                gnt_o[w_idx[PTR_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/map_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : map_port_arbiter
// Brief    : Port-B arbiter/sequencer for the map BRAM with atomic CONSUME.
//            Define MAP_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module map_port_arbiter
    import map_port_arbiter_pkg::*;
#(
    parameter int N_REQ     = 6,
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 4,
    parameter int MAP_DEPTH = 1152
) (
    input  logic                     vga_pix_clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [N_REQ*ADDR_W-1:0]  addr,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic                     bram_we,
    output logic [DATA_W-1:0]        bram_din,
    input  logic [DATA_W-1:0]        bram_dout,
    output logic                     ate_candy_stb,
    output logic                     ate_power_cookie_stb
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [DATA_W-1:0] c_empty = DATA_W'(c_empty_tile);
    localparam logic [DATA_W-1:0] c_candy = DATA_W'(c_candy_tile);
    localparam logic [DATA_W-1:0] c_power = DATA_W'(c_power_tile);

    arb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              oor_q;
    logic [N_REQ-1:0]  rvalid_q;

    logic              w_issue;
    logic [N_REQ-1:0]  w_req_eff;
    logic [N_REQ-1:0]  w_win;
    logic              w_win_any;
    logic [PTR_W-1:0]  w_ptr;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wdata;
    map_op_e           w_win_op;
    logic              w_win_oor;

    // Requests are only visible while the port is free and out of reset.
    assign w_issue   = (state_q == ST_ISSUE) && rst_n;
    assign w_req_eff = w_issue ? req : '0;
    assign w_win_any = |w_win;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i (w_req_eff),
        .ptr_i (w_ptr),
        .gnt_o (w_win)
    );

    always_comb begin
        w_win_addr  = '0;
        w_win_wdata = '0;
        w_win_op    = MAP_OP_READ;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_addr  = addr[i*ADDR_W +: ADDR_W];
                w_win_wdata = wdata[i*DATA_W +: DATA_W];
                w_win_op    = map_op_e'(op[2*i +: 2]);
            end
        end
    end

    assign w_win_oor = 32'(w_win_addr) >= MAP_DEPTH;

`ifdef MAP_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] rr_q;
    logic [PTR_W-1:0] w_win_idx;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (w_win_any) begin
            rr_q <= (w_win_idx == PTR_W'(N_REQ-1)) ? '0 : w_win_idx + PTR_W'(1);
        end
    end

    assign w_ptr = rr_q;
`else
    assign w_ptr = '0;
`endif

    // Port-B drive: writeback in RMW_WB, otherwise the current winner.
    always_comb begin
        gnt                  = w_win;
        bram_addr            = '0;
        bram_we              = 1'b0;
        bram_din             = '0;
        ate_candy_stb        = 1'b0;
        ate_power_cookie_stb = 1'b0;
        if (state_q == ST_RMW_WB) begin
            bram_addr = addr_q;
            if (!oor_q && bram_dout == c_candy) begin
                bram_we       = 1'b1;
                bram_din      = c_empty;
                ate_candy_stb = 1'b1;
            end else if (!oor_q && bram_dout == c_power) begin
                bram_we              = 1'b1;
                bram_din             = c_empty;
                ate_power_cookie_stb = 1'b1;
            end
        end else if (w_win_any) begin
            bram_addr = w_win_addr;
            if (w_win_op == MAP_OP_WRITE && !w_win_oor) begin
                bram_we  = 1'b1;
                bram_din = w_win_wdata;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = oor_q ? c_empty : bram_dout;

    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ISSUE;
            addr_q   <= '0;
            oor_q    <= 1'b0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= w_win;
            case (state_q)
                ST_ISSUE: begin
                    if (w_win_any) begin
                        addr_q <= w_win_addr;
                        oor_q  <= w_win_oor;
                        if (w_win_op == MAP_OP_CONSUME) begin
                            state_q <= ST_RMW_WB;
                        end
                    end
                end
                ST_RMW_WB: state_q <= ST_ISSUE;
                default:   state_q <= ST_ISSUE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_map_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_map_port_arbiter
// Brief    : Directed self-checking bench for map_port_arbiter with a BRAM model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_map_port_arbiter;

    localparam int N_REQ  = 6;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 1152;

    logic                    vga_pix_clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      op;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic [ADDR_W-1:0]       bram_addr;
    logic                    bram_we;
    logic [DATA_W-1:0]       bram_din;
    logic [DATA_W-1:0]       bram_dout;
    logic                    ate_candy_stb;
    logic                    ate_power_cookie_stb;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 vga_pix_clk = ~vga_pix_clk;

    map_port_arbiter #(
        .N_REQ     (N_REQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAP_DEPTH (DEPTH)
    ) dut (
        .vga_pix_clk          (vga_pix_clk),
        .rst_n                (rst_n),
        .req                  (req),
        .op                   (op),
        .addr                 (addr),
        .wdata                (wdata),
        .gnt                  (gnt),
        .rvalid               (rvalid),
        .rdata                (rdata),
        .bram_addr            (bram_addr),
        .bram_we              (bram_we),
        .bram_din             (bram_din),
        .bram_dout            (bram_dout),
        .ate_candy_stb        (ate_candy_stb),
        .ate_power_cookie_stb (ate_power_cookie_stb)
    );

    // Read-first BRAM with a bench-side preload port; out-of-range reads
    // return a candy code so the arbiter's forcing to empty is observable.
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_din;

    always @(posedge vga_pix_clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_din;
        end else if (int'(bram_addr) < DEPTH) begin
            bram_dout <= mem[bram_addr];
            if (bram_we) mem[bram_addr] <= bram_din;
        end else begin
            bram_dout <= 4'h1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge vga_pix_clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [3:0] d);
        pre_we   = 1'b1;
        pre_addr = ADDR_W'(a);
        pre_din  = d;
        cyc();
        pre_we   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input int a, input logic [3:0] d);
        logic [ADDR_W-1:0] a_w;
        a_w                    = ADDR_W'(a);
        req[i]                 = 1'b1;
        op[2*i +: 2]           = o;
        addr[i*ADDR_W +: ADDR_W] = a_w;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic rd(input int i, input int a, input logic [3:0] exp);
        set_req(i, 2'd0, a, 4'h0);
        @(negedge vga_pix_clk);
        check_vec($sformatf("rd%0d_gnt", a), 32'(gnt), 32'(1 << i));
        cyc();
        req[i] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec($sformatf("rd%0d_rvalid", a), 32'(rvalid), 32'(1 << i));
        check_vec($sformatf("rd%0d_rdata", a), 32'(rdata), 32'(exp));
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; op = '0; addr = '0; wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_din = '0;
        repeat (2) @(posedge vga_pix_clk);
        #1;
        preload(33, 4'h1); preload(40, 4'h1); preload(41, 4'h2);
        preload(42, 4'h3); preload(50, 4'h1); preload(100, 4'h0);

        @(negedge vga_pix_clk);
        check_vec("rst_gnt", 32'(gnt), 0);
        check_vec("rst_rvalid", 32'(rvalid), 0);
        check_vec("rst_we", 32'(bram_we), 0);
        check_vec("rst_addr", 32'(bram_addr), 0);
        check_vec("rst_stb", 32'({ate_candy_stb, ate_power_cookie_stb}), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single READ from requester 2
        set_req(2, 2'd0, 33, 4'h0);
        @(negedge vga_pix_clk);
        check_vec("read_gnt", 32'(gnt), 32'h04);
        check_vec("read_addr", 32'(bram_addr), 33);
        check_vec("read_we", 32'(bram_we), 0);
        cyc();
        req[2] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("read_rvalid", 32'(rvalid), 32'h04);
        check_vec("read_rdata", 32'(rdata), 1);
        check_vec("read_gnt_off", 32'(gnt), 0);
        cyc();

        // WRITE returns pre-write data, then read back
        set_req(4, 2'd1, 100, 4'h7);
        @(negedge vga_pix_clk);
        check_vec("wr_gnt", 32'(gnt), 32'h10);
        check_vec("wr_we", 32'(bram_we), 1);
        check_vec("wr_din", 32'(bram_din), 7);
        cyc();
        req[4] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("wr_rvalid", 32'(rvalid), 32'h10);
        check_vec("wr_rdata_old", 32'(rdata), 0);
        cyc();
        rd(4, 100, 4'h7);

        // CONSUME candy with a READ waiting behind it
        set_req(0, 2'd2, 40, 4'h0);
        set_req(3, 2'd0, 33, 4'h0);
        @(negedge vga_pix_clk);
        check_vec("cons_gnt", 32'(gnt), 32'h01);
        check_vec("cons_we_t", 32'(bram_we), 0);
        cyc();
        req[0] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("cons_no_gnt", 32'(gnt), 0);
        check_vec("cons_rvalid", 32'(rvalid), 32'h01);
        check_vec("cons_rdata", 32'(rdata), 1);
        check_vec("cons_stb", 32'({ate_candy_stb, ate_power_cookie_stb}), 32'b10);
        check_vec("cons_we", 32'(bram_we), 1);
        check_vec("cons_din", 32'(bram_din), 0);
        check_vec("cons_wb_addr", 32'(bram_addr), 40);
        cyc();
        @(negedge vga_pix_clk);
        check_vec("cons_next_gnt", 32'(gnt), 32'h08);
        cyc();
        req[3] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("cons_next_rdata", 32'(rdata), 1);
        cyc();
        rd(0, 40, 4'h0);

        // CONSUME power cookie
        set_req(0, 2'd2, 41, 4'h0);
        @(negedge vga_pix_clk);
        cyc();
        req[0] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("pwr_rdata", 32'(rdata), 2);
        check_vec("pwr_stb", 32'({ate_candy_stb, ate_power_cookie_stb}), 32'b01);
        check_vec("pwr_we", 32'(bram_we), 1);
        cyc();
        rd(1, 41, 4'h0);

        // CONSUME wall: no write, no strobe
        set_req(0, 2'd2, 42, 4'h0);
        @(negedge vga_pix_clk);
        cyc();
        req[0] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("wall_rdata", 32'(rdata), 3);
        check_vec("wall_we", 32'(bram_we), 0);
        check_vec("wall_stb", 32'({ate_candy_stb, ate_power_cookie_stb}), 0);
        cyc();
        rd(0, 42, 4'h3);

        // Out-of-range WRITE and CONSUME
        set_req(1, 2'd1, 1200, 4'h5);
        @(negedge vga_pix_clk);
        check_vec("oor_wr_gnt", 32'(gnt), 32'h02);
        check_vec("oor_wr_we", 32'(bram_we), 0);
        cyc();
        req[1] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("oor_wr_rvalid", 32'(rvalid), 32'h02);
        check_vec("oor_wr_rdata", 32'(rdata), 0);
        cyc();
        set_req(0, 2'd2, 1500, 4'h0);
        @(negedge vga_pix_clk);
        check_vec("oor_cons_gnt", 32'(gnt), 32'h01);
        cyc();
        req[0] = 1'b0;
        @(negedge vga_pix_clk);
        check_vec("oor_cons_rdata", 32'(rdata), 0);
        check_vec("oor_cons_we", 32'(bram_we), 0);
        check_vec("oor_cons_stb", 32'({ate_candy_stb, ate_power_cookie_stb}), 0);
        cyc();

        // Contention from a fresh pointer
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 2'd0, 33, 4'h0);
        for (int k = 0; k < N_REQ; k++) begin
            @(negedge vga_pix_clk);
`ifdef MAP_ARB_ROUND_ROBIN_EN
            check_vec($sformatf("cont_gnt%0d", k), 32'(gnt), 32'(1 << k));
`else
            check_vec($sformatf("cont_gnt%0d", k), 32'(gnt), 32'h01);
`endif
            cyc();
        end
        req = '0;
        cyc();

        // Reset during the writeback cycle aborts it
        set_req(0, 2'd2, 50, 4'h0);
        @(negedge vga_pix_clk);
        check_vec("rmw_rst_gnt", 32'(gnt), 32'h01);
        cyc();
        req[0] = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_vec("rmw_rst_we", 32'(bram_we), 0);
        check_vec("rmw_rst_stb", 32'({ate_candy_stb, ate_power_cookie_stb}), 0);
        check_vec("rmw_rst_rvalid", 32'(rvalid), 0);
        check_vec("rmw_rst_addr", 32'(bram_addr), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check_vec("rmw_rst_mem", 32'(mem[50]), 1);
        rd(0, 50, 4'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
